// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the coordinate type used by the display pipeline.
package vga_pkg;

    typedef logic [10:0] coord_t;

    localparam int COORD_SPAN = 2048;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter plus visible/sync decode of the
// next-state count, so a register stage fed by these flags lines up with count.
module timing_axis
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    input  coord_t wrap_val,
    input  coord_t sync_start,
    input  coord_t sync_last,
    input  coord_t vis_last,
    output coord_t count,
    output logic   visible,
    output logic   sync,
    output logic   at_last
);

    coord_t count_next;

    assign at_last = (count == wrap_val);

    always_comb begin
        count_next = count;
        if (inc) begin
            count_next = at_last ? '0 : count + 11'd1;
        end
    end

    // Inclusive limits keep the compares inside 11 bits even when a window ends at 2048.
    assign visible = (count_next <= vis_last);
    assign sync    = (count_next >= sync_start) && (count_next <= sync_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enable divider, col/row counters and registered
// VGA sync/blank/clock outputs plus a per-frame strobe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CLK_DIV   = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_L,
    output logic [10:0] col,
    output logic [10:0] row,
    output logic        pix_en,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_CLK,
    output logic        frame_start
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = $clog2(CLK_DIV);

    if (H_TOT > COORD_SPAN || V_TOT > COORD_SPAN) begin : g_span_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
    end
    if (CLK_DIV < 2) begin : g_div_chk
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
    if (H_VISIBLE < 1 || V_VISIBLE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_win_chk
        $error("vga_timing_gen: visible and sync widths must be non-zero");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             tick;
    logic             h_visible, h_sync, h_at_last;
    logic             v_visible, v_sync, v_at_last;

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign div_next = tick ? '0 : div_cnt + DIV_W'(1);

    timing_axis u_h_axis (
        .clk        (CLOCK_50),
        .rst_n      (reset_L),
        .inc        (tick),
        .wrap_val   (11'(H_TOT - 1)),
        .sync_start (11'(H_VISIBLE + H_FRONT)),
        .sync_last  (11'(H_VISIBLE + H_FRONT + H_SYNC - 1)),
        .vis_last   (11'(H_VISIBLE - 1)),
        .count      (col),
        .visible    (h_visible),
        .sync       (h_sync),
        .at_last    (h_at_last)
    );

    timing_axis u_v_axis (
        .clk        (CLOCK_50),
        .rst_n      (reset_L),
        .inc        (tick && h_at_last),
        .wrap_val   (11'(V_TOT - 1)),
        .sync_start (11'(V_VISIBLE + V_FRONT)),
        .sync_last  (11'(V_VISIBLE + V_FRONT + V_SYNC - 1)),
        .vis_last   (11'(V_VISIBLE - 1)),
        .count      (row),
        .visible    (v_visible),
        .sync       (v_sync),
        .at_last    (v_at_last)
    );

    // Axis flags decode the next count, so registering them here keeps every
    // output on the same edge as col/row.
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            frame_start <= 1'b0;
            VGA_CLK     <= 1'b0;
            VGA_BLANK_N <= 1'b1;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
        end else begin
            div_cnt     <= div_next;
            pix_en      <= tick;
            frame_start <= tick && h_at_last && v_at_last;
            VGA_CLK     <= (div_next >= DIV_W'(CLK_DIV / 2));
            VGA_BLANK_N <= h_visible && v_visible;
            VGA_HS      <= h_sync ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= v_sync ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameter sets share one clock and
// reset; expected outputs come from a closed-form raster model per cycle.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int HV [NI]  = '{640, 4, 5};
    localparam int HF [NI]  = '{16, 1, 2};
    localparam int HSW[NI]  = '{96, 2, 3};
    localparam int HB [NI]  = '{48, 1, 2};
    localparam int VV [NI]  = '{480, 3, 4};
    localparam int VF [NI]  = '{10, 1, 2};
    localparam int VSW[NI]  = '{2, 1, 2};
    localparam int VB [NI]  = '{33, 1, 1};
    localparam bit PL [NI]  = '{1'b0, 1'b0, 1'b1};
    localparam int DV [NI]  = '{2, 4, 3};

    typedef struct {
        int col;
        int row;
        bit pix;
        bit vclk;
        bit blank;
        bit hs;
        bit vs;
        bit fs;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset_L;
    logic [10:0] col_o [NI];
    logic [10:0] row_o [NI];
    logic        pix_o [NI];
    logic        hs_o  [NI];
    logic        vs_o  [NI];
    logic        blk_o [NI];
    logic        vclk_o[NI];
    logic        fs_o  [NI];

    exp_t sb[NI][$];
    int   c[NI];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_gen #(
            .H_VISIBLE (HV[g]),
            .H_FRONT   (HF[g]),
            .H_SYNC    (HSW[g]),
            .H_BACK    (HB[g]),
            .V_VISIBLE (VV[g]),
            .V_FRONT   (VF[g]),
            .V_SYNC    (VSW[g]),
            .V_BACK    (VB[g]),
            .SYNC_POL  (PL[g]),
            .CLK_DIV   (DV[g])
        ) u_dut (
            .CLOCK_50    (CLOCK_50),
            .reset_L     (reset_L),
            .col         (col_o[g]),
            .row         (row_o[g]),
            .pix_en      (pix_o[g]),
            .VGA_HS      (hs_o[g]),
            .VGA_VS      (vs_o[g]),
            .VGA_BLANK_N (blk_o[g]),
            .VGA_CLK     (vclk_o[g]),
            .frame_start (fs_o[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Outputs after c clock edges since reset release, from pixel arithmetic.
    function automatic exp_t model(input int i, input int c_now);
        exp_t e;
        int   n  = c_now / DV[i];
        int   ht = HV[i] + HF[i] + HSW[i] + HB[i];
        int   vt = VV[i] + VF[i] + VSW[i] + VB[i];
        e.col   = n % ht;
        e.row   = (n / ht) % vt;
        e.pix   = (c_now > 0) && (c_now % DV[i] == 0);
        e.vclk  = (c_now % DV[i]) >= (DV[i] / 2);
        e.blank = (e.col < HV[i]) && (e.row < VV[i]);
        e.hs    = (e.col >= HV[i] + HF[i] && e.col < HV[i] + HF[i] + HSW[i]) ? PL[i] : !PL[i];
        e.vs    = (e.row >= VV[i] + VF[i] && e.row < VV[i] + VF[i] + VSW[i]) ? PL[i] : !PL[i];
        e.fs    = e.pix && (e.col == 0) && (e.row == 0);
        return e;
    endfunction

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (reset_L) begin
            for (int i = 0; i < NI; i++) begin
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    chk($sformatf("i%0d col", i),         32'(col_o[i]),  32'(e.col));
                    chk($sformatf("i%0d row", i),         32'(row_o[i]),  32'(e.row));
                    chk($sformatf("i%0d pix_en", i),      32'(pix_o[i]),  32'(e.pix));
                    chk($sformatf("i%0d VGA_CLK", i),     32'(vclk_o[i]), 32'(e.vclk));
                    chk($sformatf("i%0d VGA_BLANK_N", i), 32'(blk_o[i]),  32'(e.blank));
                    chk($sformatf("i%0d VGA_HS", i),      32'(hs_o[i]),   32'(e.hs));
                    chk($sformatf("i%0d VGA_VS", i),      32'(vs_o[i]),   32'(e.vs));
                    chk($sformatf("i%0d frame_start", i), 32'(fs_o[i]),   32'(e.fs));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s i%0d col", tag, i),         32'(col_o[i]),  32'd0);
            chk($sformatf("%s i%0d row", tag, i),         32'(row_o[i]),  32'd0);
            chk($sformatf("%s i%0d pix_en", tag, i),      32'(pix_o[i]),  32'd0);
            chk($sformatf("%s i%0d VGA_CLK", tag, i),     32'(vclk_o[i]), 32'd0);
            chk($sformatf("%s i%0d VGA_BLANK_N", tag, i), 32'(blk_o[i]),  32'd1);
            chk($sformatf("%s i%0d VGA_HS", tag, i),      32'(hs_o[i]),   32'(!PL[i]));
            chk($sformatf("%s i%0d VGA_VS", tag, i),      32'(vs_o[i]),   32'(!PL[i]));
            chk($sformatf("%s i%0d frame_start", tag, i), 32'(fs_o[i]),   32'd0);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        if (reset_L) begin
            for (int i = 0; i < NI; i++) begin
                c[i]++;
                sb[i].push_back(model(i, c[i]));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        #1 reset_L = 1'b0;
        #1 check_reset_state("async_rst");
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d scoreboard drained", i), 32'(sb[i].size()), 32'd0);
            sb[i].delete();
            c[i] = 0;
        end
        repeat (2) @(posedge CLOCK_50);
        #1 check_reset_state("rst_hold");
        reset_L = 1'b1;
    endtask

    task automatic run_until(input int i, input int period, input int target);
        int k = 0;
        while (((period > 0) ? (c[i] % period) : c[i]) != target && k < 4000) begin
            step();
            k++;
        end
        chk($sformatf("i%0d reached cycle %0d", i, target),
            32'(((period > 0) ? (c[i] % period) : c[i]) == target), 32'd1);
    endtask

    initial begin
        reset_L = 1'b0;
        for (int i = 0; i < NI; i++) c[i] = 0;
        repeat (2) @(posedge CLOCK_50);
        #1 check_reset_state("por");
        reset_L = 1'b1;

        repeat (3300) step();

        // Default timing: col 700 of a line, inside the HS pulse.
        run_until(0, 1600, 1401);
        do_reset();

        // Small timing: (5,4), inside both the HS and VS pulses.
        run_until(1, 0, 149);
        do_reset();

        repeat (6) begin
            repeat ($urandom_range(20, 1800)) step();
            do_reset();
        end

        repeat (500) step();
        @(negedge CLOCK_50);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d final scoreboard empty", i), 32'(sb[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
